// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundle of the two requester handshakes (instruction fetch, data load/store)
//   and the shared memory port used by mem_port_arbiter.
//   Modports:
//     slave  - arbiter view: takes requests and mem_rdata, drives acks, read data
//              and the memory port controls.
//     master - environment view: drives requests and mem_rdata, observes the rest.
//   Signals:
//     if_req/if_addr/if_ack/if_rdata           fetch requester
//     d_req/d_we/d_addr/d_wdata/d_ack/d_rdata/d_err   data requester
//     mem_addr/mem_wdata/mem_write/mem_read/mem_rdata  unified memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, d_err,
           mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, d_err,
           mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified instruction/data memory port between instruction fetch
//   (read-only) and data load/store. Each access takes three cycles: arbitrate
//   in IDLE, drive the memory port for one cycle in ACCESS (capturing read data
//   at its closing edge), then pulse the granted ack in RESP.
//   Ports:
//     clock_i  - single clock, all state on posedge
//     reset_i  - synchronous, active-high
//     port_if  - mem_port_arbiter_if.slave (requesters + memory port)
//     busy_o   - high whenever the FSM is not in IDLE
//   Build option:
//     MEM_ARB_RR_EN - when defined, simultaneous requests alternate using a
//                     last-grant register (resets to DATA); otherwise DATA
//                     always wins a tie.
//
//   state  | meaning
//   IDLE   | waiting for a request; picks the grant
//   ACCESS | memory port driven for the granted requester; read data captured
//   RESP   | granted ack pulsed; returns to IDLE
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock_i,
  input  logic                reset_i,
  mem_port_arbiter_if.slave   port_if,
  output logic                busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_FETCH, GNT_DATA} grant_e;

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic              if_ack;
  logic              d_ack;
  logic              d_misaligned;
  grant_e            pick;

`ifdef MEM_ARB_RR_EN
  logic              last_data_q, last_data_d;
`endif

  assign d_misaligned = (port_if.d_addr[1:0] != 2'b00);

  // Winner of the IDLE arbitration, only meaningful when someone is requesting.
`ifdef MEM_ARB_RR_EN
  always_comb begin
    pick = GNT_NONE;
    if (port_if.d_req && port_if.if_req) begin
      pick = last_data_q ? GNT_FETCH : GNT_DATA;
    end else if (port_if.d_req) begin
      pick = GNT_DATA;
    end else if (port_if.if_req) begin
      pick = GNT_FETCH;
    end
  end
`else
  always_comb begin
    pick = GNT_NONE;
    if (port_if.d_req) begin
      pick = GNT_DATA;
    end else if (port_if.if_req) begin
      pick = GNT_FETCH;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    d_err_d    = d_err_q;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    if_ack     = 1'b0;
    d_ack      = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_data_d = last_data_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick != GNT_NONE) begin
          grant_d = pick;
          state_d = ST_ACCESS;
`ifdef MEM_ARB_RR_EN
          last_data_d = (pick == GNT_DATA);
`endif
        end
      end

      ST_ACCESS: begin
        state_d = ST_RESP;
        if (grant_q == GNT_FETCH) begin
          // Fetch ignores the byte offset: always a whole aligned word.
          mem_addr   = port_if.if_addr & ~(ADDR_W'(3));
          mem_read   = 1'b1;
          if_rdata_d = port_if.mem_rdata;
        end else begin
          mem_addr  = port_if.d_addr;
          mem_wdata = port_if.d_wdata;
          // A misaligned data access never touches memory and reports an error.
          mem_read  = !port_if.d_we && !d_misaligned;
          mem_write = port_if.d_we && !d_misaligned;
          d_err_d   = d_misaligned;
          d_rdata_d = (port_if.d_we || d_misaligned) ? '0 : port_if.mem_rdata;
        end
      end

      ST_RESP: begin
        if_ack  = (grant_q == GNT_FETCH);
        d_ack   = (grant_q == GNT_DATA);
        grant_d = GNT_NONE;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase

    // Reset is synchronous, so the current cycle is still live: keep a store
    // from landing and an ack from escaping while reset is high.
    if (reset_i) begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      if_ack    = 1'b0;
      d_ack     = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= GNT_NONE;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      d_err_q    <= d_err_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      last_data_q <= 1'b1;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`endif

  assign port_if.mem_addr  = mem_addr;
  assign port_if.mem_wdata = mem_wdata;
  assign port_if.mem_write = mem_write;
  assign port_if.mem_read  = mem_read;
  assign port_if.if_ack    = if_ack;
  assign port_if.d_ack     = d_ack;
  assign port_if.if_rdata  = if_rdata_q;
  assign port_if.d_rdata   = d_rdata_q;
  // The error register holds its value between accesses; expose it only with the ack.
  assign port_if.d_err     = d_err_q & d_ack;
  assign busy_o            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .port_if (bus),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_wr     = 0;
  int n_rd     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Small sparse memory: region bit 28 selects 0x1001xxxx vs 0x0040xxxx.
  function automatic int widx(input logic [31:0] a);
    return (a[28] ? 16 : 0) + int'(a[5:2]);
  endfunction

  logic [31:0] phys_mem [32];
  logic [31:0] ref_mem  [32];

  assign bus.mem_rdata = bus.mem_read ? phys_mem[widx(bus.mem_addr)] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 32; i++) phys_mem[i] <= 32'h0;
      phys_mem[widx(32'h0040_0004)] <= 32'h0044_2483;
      phys_mem[widx(32'h1001_0008)] <= 32'hCAFE_F00D;
    end else if (bus.mem_write) begin
      phys_mem[widx(bus.mem_addr)] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level reference: each accepted request occupies the port for
  // the cycle after it is sampled and is acknowledged one cycle after that.
  bit          m_on = 1'b0;
  int          m_stage = 0;
  bit          m_data;
  bit          m_we;
  bit          m_err;
  bit          m_last_data = 1'b1;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] exp_if = '0;
  logic [31:0] exp_d  = '0;

  always @(negedge clk) begin
    logic        e_rd, e_wr, e_ifa, e_da, chk_bus, pick_data;
    logic [31:0] e_addr, e_wdata;
    e_rd = 0; e_wr = 0; e_ifa = 0; e_da = 0; chk_bus = 1;
    e_addr = '0; e_wdata = '0; pick_data = 0;
    if (bus.mem_write) n_wr++;
    if (bus.mem_read)  n_rd++;

    if (m_stage == 1 && !rst) begin
      if (!m_data) begin
        e_rd = 1; e_addr = {m_addr[31:2], 2'b00};
      end else if (m_addr[1:0] != 2'b00) begin
        chk_bus = 0;
      end else begin
        e_rd = !m_we; e_wr = m_we; e_addr = m_addr; e_wdata = m_wdata;
      end
    end
    if (m_stage == 2 && !rst) begin
      e_ifa = !m_data; e_da = m_data;
    end

    if (m_on) begin
      chk("busy",      busy,          m_stage != 0);
      chk("mem_read",  bus.mem_read,  e_rd);
      chk("mem_write", bus.mem_write, e_wr);
      if (chk_bus) begin
        chk("mem_addr",  bus.mem_addr,  e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wdata);
      end
      chk("if_ack",   bus.if_ack,   e_ifa);
      chk("d_ack",    bus.d_ack,    e_da);
      chk("d_err",    bus.d_err,    e_da && m_err);
      chk("if_rdata", bus.if_rdata, exp_if);
      chk("d_rdata",  bus.d_rdata,  exp_d);
    end

    if (rst) begin
      if (!m_on) begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        ref_mem[widx(32'h0040_0004)] = 32'h0044_2483;
        ref_mem[widx(32'h1001_0008)] = 32'hCAFE_F00D;
      end
      m_stage = 0; exp_if = '0; exp_d = '0; m_last_data = 1'b1; m_on = 1'b1;
    end else begin
      case (m_stage)
        0: if (bus.if_req || bus.d_req) begin
`ifdef MEM_ARB_RR_EN
             pick_data = bus.d_req && (!bus.if_req || !m_last_data);
`else
             pick_data = bus.d_req;
`endif
             m_last_data = pick_data;
             m_data  = pick_data;
             m_addr  = pick_data ? bus.d_addr : bus.if_addr;
             m_we    = pick_data && bus.d_we;
             m_wdata = bus.d_wdata;
             m_stage = 1;
           end
        1: begin
             if (!m_data) begin
               exp_if = ref_mem[widx(m_addr)];
             end else begin
               m_err = (m_addr[1:0] != 2'b00);
               if (m_err) exp_d = '0;
               else if (m_we) begin
                 ref_mem[widx(m_addr)] = m_wdata;
                 exp_d = '0;
               end else exp_d = ref_mem[widx(m_addr)];
             end
             m_stage = 2;
           end
        default: m_stage = 0;
      endcase
    end
  end

  task automatic wait_ack(input bit data, input int budget, output int ack_cyc);
    bit ok;
    ok = 0; ack_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (data ? bus.d_ack : bus.if_ack) begin
        ok = 1; ack_cyc = cyc;
        break;
      end
    end
    chk(data ? "d_ack_seen" : "if_ack_seen", ok, 1'b1);
  endtask

  task automatic do_fetch(input logic [31:0] a, output logic [31:0] rd, output int lat);
    int c0, ca;
    @(posedge clk); #1;
    bus.if_req = 1; bus.if_addr = a; c0 = cyc;
    wait_ack(0, 10, ca);
    rd = bus.if_rdata; lat = ca - c0;
    @(posedge clk); #1;
    bus.if_req = 0;
  endtask

  task automatic do_data(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat);
    int c0, ca;
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; c0 = cyc;
    wait_ack(1, 10, ca);
    rd = bus.d_rdata; err = bus.d_err; lat = ca - c0;
    @(posedge clk); #1;
    bus.d_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat, wr0, rd0, cd, cf, c0;
    bit          prev_data, cur_data, got;

    rst = 1;
    bus.if_req = 1; bus.if_addr = 32'h0040_0004;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h1001_0000; bus.d_wdata = 32'h55;

    // Reset with both requests high.
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",      busy,          1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_read",  bus.mem_read,  1'b0);
    chk("rst_mem_addr",  bus.mem_addr,  32'h0);
    chk("rst_acks",      {bus.if_ack, bus.d_ack}, 2'b00);
    chk("rst_if_rdata",  bus.if_rdata,  32'h0);
    chk("rst_d_rdata",   bus.d_rdata,   32'h0);
    @(posedge clk); #1;
    rst = 0; bus.if_req = 0; bus.d_req = 0; bus.d_we = 0;

    // Lone fetch.
    do_fetch(32'h0040_0004, rd, lat);
    chk("fetch_rdata",   rd,  32'h0044_2483);
    chk("fetch_latency", lat, 2);

    // Misaligned fetch is word-aligned.
    do_fetch(32'h0040_0007, rd, lat);
    chk("fetch_unaligned_rdata", rd, 32'h0044_2483);

    // Store then load back.
    wr0 = n_wr;
    do_data(1, 32'h1001_0000, 32'd255, rd, err, lat);
    chk("store_rdata",  rd,  32'h0);
    chk("store_err",    err, 1'b0);
    chk("store_writes", n_wr - wr0, 1);
    chk("store_latency", lat, 2);
    do_data(0, 32'h1001_0000, 32'h0, rd, err, lat);
    chk("load_rdata", rd,  32'd255);
    chk("load_err",   err, 1'b0);

    // Simultaneous requests.
`ifdef MEM_ARB_RR_EN
    @(posedge clk); #1;
    bus.if_req = 1; bus.if_addr = 32'h0040_0004;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1001_0000;
    prev_data = 0;
    for (int k = 0; k < 8; k++) begin
      got = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus.if_ack || bus.d_ack) begin
          got = 1; cur_data = bus.d_ack;
          break;
        end
      end
      chk("rr_ack_seen", got, 1'b1);
      if (k > 0) chk("rr_alternate", cur_data, !prev_data);
      prev_data = cur_data;
    end
    @(posedge clk); #1;
    bus.if_req = 0; bus.d_req = 0;
`else
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus.if_req = 1; bus.if_addr = 32'h0040_0004;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1001_0000; c0 = cyc;
      wait_ack(1, 10, cd);
      chk("pri_data_first", cd - c0, 2);
      chk("pri_data_rdata", bus.d_rdata, 32'd255);
      @(posedge clk); #1;
      bus.d_req = 0;
      wait_ack(0, 10, cf);
      chk("pri_fetch_gap",   cf - cd, 3);
      chk("pri_fetch_rdata", bus.if_rdata, 32'h0044_2483);
      @(posedge clk); #1;
      bus.if_req = 0;
    end
`endif

    // Misaligned load and store.
    wr0 = n_wr; rd0 = n_rd;
    do_data(0, 32'h1001_0006, 32'h0, rd, err, lat);
    chk("mis_load_err",   err, 1'b1);
    chk("mis_load_rdata", rd,  32'h0);
    chk("mis_load_reads", n_rd - rd0, 0);
    do_data(1, 32'h1001_0005, 32'hFFFF_FFFF, rd, err, lat);
    chk("mis_store_err",    err, 1'b1);
    chk("mis_store_writes", n_wr - wr0, 0);
    do_data(0, 32'h1001_0004, 32'h0, rd, err, lat);
    chk("mis_store_nowrite", rd, 32'h0);

    // Reset during the ACCESS cycle of a store.
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h1001_0008; bus.d_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    rst = 1; bus.d_req = 0;
    @(negedge clk);
    chk("rst_access_busy",  busy,          1'b1);
    chk("rst_access_write", bus.mem_write, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_access_idle",  busy,      1'b0);
    chk("rst_access_noack", bus.d_ack, 1'b0);
    chk("rst_access_word",  phys_mem[widx(32'h1001_0008)], 32'hCAFE_F00D);

    do_data(0, 32'h1001_0008, 32'h0, rd, err, lat);
    chk("post_rst_load", rd, 32'hCAFE_F00D);
    do_fetch(32'h0040_0004, rd, lat);
    chk("post_rst_fetch", rd, 32'h0044_2483);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
